// File: rtl/axis_noc_inject_mux.sv
// Multi-source AXI-Stream injector for a NoC router local port: packet-atomic
// round-robin arbitration, beat-to-flit serialisation and credit flow control.
module axis_noc_inject_mux #(
  parameter int NUM_CHANNELS         = 4,
  parameter int TDATA_WIDTH          = 32,
  parameter int TID_WIDTH            = 2,
  parameter int TDEST_WIDTH          = 2,
  parameter int SERIALIZATION_FACTOR = 1,
  parameter int FLIT_BUFFER_DEPTH    = 8,
  parameter int DEST_WIDTH           = TDEST_WIDTH + TID_WIDTH,
  parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
  parameter int CW                   = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                                         clk_noc,
  input  logic                                         rst_n,
  input  logic [NUM_CHANNELS-1:0]                      s_axis_tvalid,
  output logic [NUM_CHANNELS-1:0]                      s_axis_tready,
  input  logic [NUM_CHANNELS-1:0][TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [NUM_CHANNELS-1:0]                      s_axis_tlast,
  input  logic [NUM_CHANNELS-1:0][TID_WIDTH-1:0]       s_axis_tid,
  input  logic [NUM_CHANNELS-1:0][TDEST_WIDTH-1:0]     s_axis_tdest,
  output logic [FLIT_WIDTH-1:0]                        data_out,
  output logic [DEST_WIDTH-1:0]                        dest_out,
  output logic                                         is_tail_out,
  output logic                                         send_out,
  input  logic                                         credit_in,
  output logic [CW-1:0]                                credit_count,
  output logic                                         credit_overflow,
  output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] grant,
  output logic                                         busy
);

  localparam int GW     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int SF     = SERIALIZATION_FACTOR;
  localparam int FIDX_W = (SF > 1) ? $clog2(SF) : 1;
  localparam logic [FIDX_W-1:0] FIDX_LAST  = FIDX_W'(SF - 1);
  localparam logic [CW-1:0]     CREDIT_MAX = CW'(FLIT_BUFFER_DEPTH);
  localparam logic [GW-1:0]     LAST_CH    = GW'(NUM_CHANNELS - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [GW-1:0]           rr_ptr, rr_ptr_nxt, grant_nxt;
  logic                    any_valid;
  logic                    hold_valid, hold_last, tail_taken;
  logic [TDATA_WIDTH-1:0]  hold_data;
  logic [DEST_WIDTH-1:0]   hold_dest;
  logic [FIDX_W-1:0]       fidx;
  logic                    fire, fidx_last, tail_fire, can_take, take;
  logic [FLIT_WIDTH-1:0]   flit_sel;

  // Cyclic search for the first requesting channel at or after rr_ptr
  always_comb begin
    logic [GW-1:0] idx;
    idx       = '0;
    grant_nxt = grant;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      idx = GW'((int'(rr_ptr) + i) % NUM_CHANNELS);
      if (!any_valid && s_axis_tvalid[idx]) begin
        any_valid = 1'b1;
        grant_nxt = idx;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: if (any_valid) begin
        state_nxt  = SEND;
        rr_ptr_nxt = (grant_nxt == LAST_CH) ? '0 : grant_nxt + GW'(1);
      end
      SEND: if (tail_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign fire      = hold_valid && (credit_count != '0);
  assign fidx_last = (fidx == FIDX_LAST);
  assign tail_fire = fire && hold_last && fidx_last;
  // A new beat may enter while the last flit of the held beat leaves
  assign can_take  = (state == SEND) && !tail_taken && (!hold_valid || (fire && fidx_last));
  assign take      = can_take && s_axis_tvalid[grant];
  assign flit_sel  = FLIT_WIDTH'(hold_data >> (int'(fidx) * FLIT_WIDTH));
  assign busy      = (state == SEND);

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ready
    assign s_axis_tready[g] = can_take && (grant == GW'(g));
  end

  // Stage 0: beat hold register (payload only; qualified by hold_valid)
  always_ff @(posedge clk_noc) begin
    if (take) begin
      hold_data <= s_axis_tdata[grant];
      hold_dest <= {s_axis_tid[grant], s_axis_tdest[grant]};
      hold_last <= s_axis_tlast[grant];
    end
  end

  // Stage 1: control, credits and registered flit outputs
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      grant           <= '0;
      hold_valid      <= 1'b0;
      tail_taken      <= 1'b0;
      fidx            <= '0;
      credit_count    <= CREDIT_MAX;
      credit_overflow <= 1'b0;
      send_out        <= 1'b0;
      is_tail_out     <= 1'b0;
      data_out        <= '0;
      dest_out        <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      if (state == IDLE && any_valid) grant <= grant_nxt;

      if (state_nxt == IDLE)                tail_taken <= 1'b0;
      else if (take && s_axis_tlast[grant]) tail_taken <= 1'b1;

      if (take)                   hold_valid <= 1'b1;
      else if (fire && fidx_last) hold_valid <= 1'b0;

      if (fire) fidx <= fidx_last ? '0 : fidx + FIDX_W'(1);

      case ({fire, credit_in})
        2'b10:   credit_count <= credit_count - CW'(1);
        2'b01: begin
          if (credit_count == CREDIT_MAX) credit_overflow <= 1'b1;
          else                            credit_count    <= credit_count + CW'(1);
        end
        default: ;
      endcase

      send_out <= fire;
      if (fire) begin
        data_out    <= flit_sel;
        dest_out    <= hold_dest;
        is_tail_out <= hold_last && fidx_last;
      end
    end
  end

endmodule

// File: tb/tb_axis_noc_inject_mux.sv
// Scoreboard bench: instance A (4 ch, 1 flit/beat, 8 credits) and
// instance B (2 ch, 4 flits/beat, 2 credits, router credit-return model).
module tb_axis_noc_inject_mux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp_v);
  endtask

  // ---------------- instance A ----------------
  logic        tv_a [4];
  logic [31:0] td_a [4];
  logic        tl_a [4];
  logic [1:0]  tid_a [4];
  logic [1:0]  tdst_a [4];
  logic [3:0]  valid_a, last_a, tready_a;
  logic [3:0][31:0] data_a;
  logic [3:0][1:0]  id_a, dst_a;
  logic [31:0] flit_a;
  logic [3:0]  dest_oa, ccnt_a;
  logic        tail_a, send_a, cr_a, ovf_a, busy_a;
  logic [1:0]  grant_a;

  always_comb begin
    valid_a = '0; last_a = '0; data_a = '0; id_a = '0; dst_a = '0;
    for (int i = 0; i < 4; i++) begin
      valid_a[i] = tv_a[i]; last_a[i] = tl_a[i]; data_a[i] = td_a[i];
      id_a[i] = tid_a[i]; dst_a[i] = tdst_a[i];
    end
  end

  axis_noc_inject_mux #(
    .NUM_CHANNELS(4), .TDATA_WIDTH(32), .TID_WIDTH(2), .TDEST_WIDTH(2),
    .SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(8)
  ) u_a (
    .clk_noc(clk), .rst_n(rst_n),
    .s_axis_tvalid(valid_a), .s_axis_tready(tready_a), .s_axis_tdata(data_a),
    .s_axis_tlast(last_a), .s_axis_tid(id_a), .s_axis_tdest(dst_a),
    .data_out(flit_a), .dest_out(dest_oa), .is_tail_out(tail_a), .send_out(send_a),
    .credit_in(cr_a), .credit_count(ccnt_a), .credit_overflow(ovf_a),
    .grant(grant_a), .busy(busy_a)
  );

  // ---------------- instance B ----------------
  logic        tv_b0, tl_b0;
  logic [31:0] td_b0;
  logic [1:0]  valid_b, last_b, tready_b;
  logic [1:0][31:0] data_b;
  logic [1:0][1:0]  id_b, dst_b;
  logic [7:0]  flit_b;
  logic [3:0]  dest_ob;
  logic [1:0]  ccnt_b;
  logic        tail_b, send_b, cr_b, ovf_b, busy_b, ret_b, man_b, auto_b;
  logic [0:0]  grant_b;

  assign valid_b = {1'b0, tv_b0};
  assign last_b  = {1'b0, tl_b0};
  assign data_b  = {32'h0, td_b0};
  assign id_b    = {2'd0, 2'd1};
  assign dst_b   = {2'd0, 2'd3};
  assign cr_b    = ret_b | man_b;

  axis_noc_inject_mux #(
    .NUM_CHANNELS(2), .TDATA_WIDTH(32), .TID_WIDTH(2), .TDEST_WIDTH(2),
    .SERIALIZATION_FACTOR(4), .FLIT_BUFFER_DEPTH(2)
  ) u_b (
    .clk_noc(clk), .rst_n(rst_n),
    .s_axis_tvalid(valid_b), .s_axis_tready(tready_b), .s_axis_tdata(data_b),
    .s_axis_tlast(last_b), .s_axis_tid(id_b), .s_axis_tdest(dst_b),
    .data_out(flit_b), .dest_out(dest_ob), .is_tail_out(tail_b), .send_out(send_b),
    .credit_in(cr_b), .credit_count(ccnt_b), .credit_overflow(ovf_b),
    .grant(grant_b), .busy(busy_b)
  );

  // ---------------- scoreboards ----------------
  logic [36:0] exp_a [$];
  logic [12:0] exp_b [$];
  int cyc_a [$];
  int cyc_b [$];

  always @(negedge clk) begin : mon_a
    logic [36:0] e;
    if (rst_n && send_a) begin
      cyc_a.push_back(cyc);
      if (exp_a.size() == 0) chk("a_unexpected_flit", 64'd1, 64'd0);
      else begin
        e = exp_a.pop_front();
        chk("a_flit", {tail_a, dest_oa, flit_a}, e);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [12:0] e;
    ret_b = auto_b && send_b;
    if (rst_n && send_b) begin
      cyc_b.push_back(cyc);
      if (exp_b.size() == 0) chk("b_unexpected_flit", 64'd1, 64'd0);
      else begin
        e = exp_b.pop_front();
        chk("b_flit", {tail_b, dest_ob, flit_b}, e);
      end
    end
  end

  // ---------------- drivers (called and returning at a negedge) ----------------
  task automatic beat_a(input int ch, input logic [31:0] d, input logic last,
                        input logic [1:0] id, input logic [1:0] de, output int waits);
    tv_a[ch] = 1'b1; td_a[ch] = d; tl_a[ch] = last; tid_a[ch] = id; tdst_a[ch] = de;
    waits = 0;
    while (!tready_a[ch] && waits < 300) begin @(negedge clk); waits++; end
    if (waits >= 300) chk($sformatf("a_handshake_timeout_ch%0d", ch), 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pkt_a(input int ch, input logic [31:0] base, input int n,
                       input logic [1:0] id, input logic [1:0] de);
    int w;
    for (int i = 0; i < n; i++) beat_a(ch, base + 32'(i), (i == n - 1), id, de, w);
    tv_a[ch] = 1'b0; tl_a[ch] = 1'b0;
  endtask

  task automatic push_a(input logic [31:0] base, input int n, input logic [1:0] id, input logic [1:0] de);
    for (int i = 0; i < n; i++) exp_a.push_back({(i == n - 1), id, de, base + 32'(i)});
  endtask

  task automatic drain_a();
    int t = 0;
    while (exp_a.size() != 0 && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) chk("a_drain_timeout", 64'(exp_a.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic give_a(input int n);
    cr_a = 1'b1;
    repeat (n) @(negedge clk);
    cr_a = 1'b0;
  endtask

  task automatic beat_b(input logic [31:0] d, input logic last, output int waits);
    tv_b0 = 1'b1; td_b0 = d; tl_b0 = last;
    waits = 0;
    while (!tready_b[0] && waits < 300) begin @(negedge clk); waits++; end
    if (waits >= 300) chk("b_handshake_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_b(input logic [31:0] d, input logic last);
    for (int j = 0; j < 4; j++) exp_b.push_back({(last && j == 3), 4'b0111, d[j*8 +: 8]});
  endtask

  task automatic drain_b();
    int t = 0;
    while (exp_b.size() != 0 && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) chk("b_drain_timeout", 64'(exp_b.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_chk_a(input string p);
    chk({p, "_send"}, send_a, 0);     chk({p, "_tail"}, tail_a, 0);
    chk({p, "_data"}, flit_a, 0);     chk({p, "_dest"}, dest_oa, 0);
    chk({p, "_tready"}, tready_a, 0); chk({p, "_grant"}, grant_a, 0);
    chk({p, "_busy"}, busy_a, 0);     chk({p, "_ovf"}, ovf_a, 0);
    chk({p, "_credits"}, ccnt_a, 8);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, w, k, t;
    for (int i = 0; i < 4; i++) begin
      tv_a[i] = 0; td_a[i] = 0; tl_a[i] = 0; tid_a[i] = 0; tdst_a[i] = 0;
    end
    cr_a = 0; tv_b0 = 0; tl_b0 = 0; td_b0 = 0; man_b = 0; auto_b = 0; ret_b = 0;

    #12;
    reset_chk_a("a_reset");
    chk("b_reset_credits", ccnt_b, 2);
    chk("b_reset_send", send_b, 0);
    chk("b_reset_tready", tready_b, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // A: single 3-beat packet, tid=2 tdest=1
    cyc_a.delete();
    push_a(32'hA, 3, 2'd2, 2'd1);
    c0 = cyc;
    pkt_a(3, 32'hA, 3, 2'd2, 2'd1);
    drain_a();
    chk("a_t1_nflits", 64'(cyc_a.size()), 3);
    if (cyc_a.size() >= 3) begin
      chk("a_t1_latency", 64'(cyc_a[0] - c0), 3);
      chk("a_t1_back_to_back", 64'(cyc_a[2] - cyc_a[0]), 2);
    end
    chk("a_t1_credits", ccnt_a, 5);
    chk("a_t1_rr_ptr", u_a.rr_ptr, 0);

    // A: channels 0 and 2 contend; channel 0 packet first, no interleave
    give_a(3);
    chk("a_credits_restored", ccnt_a, 8);
    push_a(32'h100, 2, 2'd0, 2'd0);
    push_a(32'h200, 2, 2'd1, 2'd2);
    fork
      pkt_a(0, 32'h100, 2, 2'd0, 2'd0);
      pkt_a(2, 32'h200, 2, 2'd1, 2'd2);
    join
    drain_a();
    chk("a_rr_ptr_after", u_a.rr_ptr, 3);
    chk("a_t2_credits", ccnt_a, 4);

    // A: saturation and sticky overflow
    give_a(4);
    chk("a_credits_full", ccnt_a, 8);
    chk("a_no_overflow_yet", ovf_a, 0);
    give_a(1);
    chk("a_credits_saturated", ccnt_a, 8);
    chk("a_overflow_set", ovf_a, 1);
    repeat (3) @(negedge clk);
    chk("a_overflow_sticky", ovf_a, 1);

    // B: 4 flits per beat, credits returned by the router model
    auto_b = 1'b1;
    cyc_b.delete();
    push_b(32'h44332211, 1'b1);
    beat_b(32'h44332211, 1'b1, w);
    tv_b0 = 0; tl_b0 = 0;
    drain_b();
    chk("b_sf_nflits", 64'(cyc_b.size()), 4);
    if (cyc_b.size() >= 4) chk("b_sf_consecutive", 64'(cyc_b[3] - cyc_b[0]), 3);
    chk("b_sf_credits_end", ccnt_b, 2);

    cyc_b.delete();
    push_b(32'h04030201, 1'b0);
    push_b(32'h08070605, 1'b1);
    beat_b(32'h04030201, 1'b0, w);
    beat_b(32'h08070605, 1'b1, w);
    tv_b0 = 0; tl_b0 = 0;
    chk("b_tready_low_cycles", 64'(w), 3);
    chk("b_fire_and_return_at_1", ccnt_b, 1);
    drain_b();
    chk("b_2beat_nflits", 64'(cyc_b.size()), 8);
    if (cyc_b.size() >= 8) chk("b_2beat_consecutive", 64'(cyc_b[7] - cyc_b[0]), 7);
    chk("b_credits_end", ccnt_b, 2);
    chk("b_no_overflow", ovf_b, 0);

    // B: stall at zero credits, then one credit pulse -> one flit
    auto_b = 1'b0;
    cyc_b.delete();
    push_b(32'hDDCCBBAA, 1'b1);
    beat_b(32'hDDCCBBAA, 1'b1, w);
    tv_b0 = 0; tl_b0 = 0;
    repeat (8) @(negedge clk);
    chk("b_stall_nflits", 64'(cyc_b.size()), 2);
    chk("b_stall_credits", ccnt_b, 0);
    chk("b_stall_send", send_b, 0);
    k = cyc;
    man_b = 1'b1;
    @(negedge clk); man_b = 1'b0;
    repeat (4) @(negedge clk);
    chk("b_one_credit_one_flit", 64'(cyc_b.size()), 3);
    if (cyc_b.size() >= 3) chk("b_credit_to_flit", 64'(cyc_b[2] - k), 2);
    man_b = 1'b1;
    @(negedge clk); man_b = 1'b0;
    drain_b();
    chk("b_stall_tail_done", 64'(cyc_b.size()), 4);

    // A: asynchronous reset in the middle of a packet
    cyc_a.delete();
    for (int i = 0; i < 10; i++) exp_a.push_back({1'b0, 2'd1, 2'd1, 32'h55});
    tv_a[1] = 1; td_a[1] = 32'h55; tl_a[1] = 0; tid_a[1] = 2'd1; tdst_a[1] = 2'd1;
    t = 0;
    while (cyc_a.size() < 2 && t < 100) begin @(negedge clk); t++; end
    chk("a_pre_reset_sending", send_a, 1);
    #2 rst_n = 1'b0;
    #1 reset_chk_a("a_async_reset");
    tv_a[1] = 0;
    exp_a.delete();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    push_a(32'h300, 2, 2'd3, 2'd3);
    pkt_a(3, 32'h300, 2, 2'd3, 2'd3);
    drain_a();
    chk("a_post_reset_grant", grant_a, 3);
    chk("a_post_reset_credits", ccnt_a, 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
